mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit; sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Decodes load/store opcodes and runs a req/ready handshake to data memory.
- Produces the extended read data (MEM_RD_DATA) that the MEM/WB register captures.
- Stalls the pipeline while an access is outstanding.

Parameters:
- ADDR_W, 32, byte-address width presented to data memory.
- TIMEOUT_CYCLES, 256, BUSY-cycle limit before bus error (used only with MEM_TIMEOUT_EN).

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- MEM_Opcode  in  6  instruction opcode from EX/MEM
- MEM_MemRead  in  1  load control from EX/MEM
- MEM_MemWrite  in  1  store control from EX/MEM
- MEM_ALU_RESULT  in  32  effective byte address
- MEM_WR_DATA  in  32  rt value to store
- MEM_RD_DATA  out  32  extended load data, registered
- MEM_STALL  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; hold MEM/WB
- MEM_MISALIGN  out  1  misaligned access flag, combinational
- MEM_BUS_ERR  out  1  timeout pulse (constant 0 without MEM_TIMEOUT_EN)
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  write data, lane-replicated
- dmem_ready  in  1  request accepted or completed
- dmem_rdata  in  32  read word, valid when dmem_ready=1

Behaviour:
- Reset values:
  - All outputs 0; MEM_RD_DATA = 0; state = IDLE.
  - RESET mid-access drops dmem_req immediately and abandons the transaction.
- Decoded opcodes:
  - Loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
  - Stores: SB 0x28, SH 0x29, SW 0x2B.
  - Any other opcode with MemRead or MemWrite set is treated as no access.
- Byte order: little-endian. addr[1:0]=0 selects bits 7:0.
- Alignment and lanes:
  - Halfword requires addr[0]=0; word requires addr[1:0]=0.
  - Misaligned access in IDLE: MEM_MISALIGN=1, no request, no stall, MEM_RD_DATA unchanged.
  - dmem_be: byte = 1<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
  - Store data: SB replicates the byte into all four lanes; SH replicates the halfword into both halves.
  - Loads: extract the selected lane, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - A valid aligned access asserts MEM_STALL=1 combinationally.
  - At the clock edge: latch addr/be/wdata/we/opcode, set dmem_req<=1, go to BUSY.
- BUSY:
  - MEM_STALL=1; dmem_req held at 1.
  - dmem_addr/be/wdata/we stay stable until the edge where dmem_ready=1.
  - At the edge with dmem_ready=1: dmem_req<=0; for loads, MEM_RD_DATA <= extended dmem_rdata (stores leave it unchanged); go to DONE.
- DONE:
  - MEM_STALL=0 for exactly one cycle so the pipeline advances and MEM/WB captures MEM_RD_DATA.
  - No new access is accepted in DONE; go to IDLE unconditionally.
- Latency:
  - Minimum 3 cycles per access (IDLE-start, 1 BUSY, DONE).
  - Each extra cycle of dmem_ready low adds one stall cycle.
- dmem_ready high while dmem_req=0 is ignored.
- MEM_RD_DATA holds its value until the next completed load.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter runs in BUSY.
  - On reaching TIMEOUT_CYCLES without dmem_ready: drop dmem_req, set MEM_RD_DATA=0, go to DONE, and pulse MEM_BUS_ERR=1 for the DONE cycle.
  - The counter clears on entry to BUSY.
- Undefined: BUSY waits indefinitely; MEM_BUS_ERR is tied 0; no counter logic.

Decomposition:
- Package mips_mem_pkg holds:
  - opcode localparams (OP_LB … OP_SW);
  - the FSM state enum encoding;
  - access-size codes (SZ_BYTE, SZ_HALF, SZ_WORD).
- One natural combinational sub-module, lsu_lane_align, handles:
  - store-data replication and byte-enable generation;
  - load lane extraction and sign/zero extension.

Test Plan:
- LW addr 0x100, dmem_ready after 2 BUSY cycles, rdata 0x12345678 -> MEM_STALL high 3 cycles, dmem_be=1111, MEM_RD_DATA=0x12345678 in DONE.
- LB addr 0x103, rdata 0x80FF_0000 -> MEM_RD_DATA=0xFFFFFF80. Same with LBU -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201, wdata 0x000000AB -> dmem_we=1, dmem_be=0010, dmem_wdata=0xABABABAB, dmem_addr=0x200; MEM_RD_DATA unchanged.
- LW addr 0x102 -> MEM_MISALIGN=1, dmem_req never rises, MEM_STALL=0.
- RESET pulsed in BUSY -> dmem_req=0 asynchronously, MEM_STALL=0, MEM_RD_DATA=0; after release the next LW completes normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, dmem_ready held 0 -> dmem_req drops after 4 BUSY cycles, MEM_BUS_ERR pulses one cycle, MEM_RD_DATA=0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package     : mips_mem_pkg
// Description : Shared definitions for the MEM-stage load/store unit.
//               MIPS load/store opcodes, the LSU state encoding, the
//               access-size codes and small opcode decode helpers.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package mips_mem_pkg;

  // Load opcodes
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  // Store opcodes
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_t;

  function automatic logic op_is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_is_unsigned(input logic [5:0] op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic lsu_size_t op_size(input logic [5:0] op);
    lsu_size_t sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : lsu_lane_align
// Description : Combinational byte-lane steering for the load/store unit
//               (little-endian, lane 0 = bits 7:0).
//               Request side : byte enables and lane-replicated store data.
//               Load side    : lane extraction with sign/zero extension.
// Ports       : req_size/req_lane/req_data -> req_be, req_wdata
//               ld_size/ld_unsigned/ld_lane/ld_word -> ld_data
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  lsu_size_t   req_size,
  input  logic [1:0]  req_lane,
  input  logic [31:0] req_data,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata,
  input  lsu_size_t   ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Sub-word stores replicate the datum so memory can pick any lane by BE.
  always_comb begin
    req_be    = 4'b1111;
    req_wdata = req_data;
    case (req_size)
      SZ_BYTE: begin
        req_be    = 4'b0001 << req_lane;
        req_wdata = {4{req_data[7:0]}};
      end
      SZ_HALF: begin
        req_be    = req_lane[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{req_data[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = req_data;
      end
    endcase
  end

  always_comb begin
    w_byte = ld_word[7:0];
    case (ld_lane)
      2'd0:    w_byte = ld_word[7:0];
      2'd1:    w_byte = ld_word[15:8];
      2'd2:    w_byte = ld_word[23:16];
      default: w_byte = ld_word[31:24];
    endcase
    w_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];

    ld_data = ld_word;
    case (ld_size)
      SZ_BYTE: ld_data = ld_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: ld_data = ld_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mem_stage_lsu
// Description : MEM-stage load/store unit. Decodes load/store opcodes,
//               runs a req/ready handshake to data memory, stalls the
//               pipeline while an access is outstanding and registers the
//               extended load data for the MEM/WB register.
//               Sequence per access: IDLE (start) -> BUSY (>=1) -> DONE (1).
// Ports       : CLK, RESET (async, active high)
//               EX/MEM side : MEM_Opcode, MEM_MemRead, MEM_MemWrite,
//                             MEM_ALU_RESULT, MEM_WR_DATA
//               Pipeline    : MEM_RD_DATA, MEM_STALL, MEM_MISALIGN, MEM_BUS_ERR
//               Data memory : dmem_req, dmem_we, dmem_addr, dmem_be,
//                             dmem_wdata, dmem_ready, dmem_rdata
// Options     : MEM_TIMEOUT_EN - abandon a BUSY access after TIMEOUT_CYCLES
//               cycles without dmem_ready and pulse MEM_BUS_ERR in DONE.
//               Without it BUSY waits indefinitely and MEM_BUS_ERR is 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module mem_stage_lsu
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [5:0]        MEM_Opcode,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic [31:0]       MEM_ALU_RESULT,
  input  logic [31:0]       MEM_WR_DATA,
  output logic [31:0]       MEM_RD_DATA,
  output logic              MEM_STALL,
  output logic              MEM_MISALIGN,
  output logic              MEM_BUS_ERR,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata
);

  lsu_state_t        r_state;
  lsu_state_t        w_next_state;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_access;
  logic              w_misalign;
  logic              w_start;
  logic              w_complete;
  logic              w_timeout;
  logic              w_stall;
  lsu_size_t         w_size;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ld_data;

  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rd_data;
  logic              r_is_load;
  logic              r_ld_unsigned;
  lsu_size_t         r_ld_size;
  logic [1:0]        r_lane;

  // Opcode decode; unknown opcodes with MemRead/MemWrite mean no access.
  always_comb begin
    w_is_load  = MEM_MemRead  && op_is_load(MEM_Opcode);
    w_is_store = MEM_MemWrite && op_is_store(MEM_Opcode);
    w_access   = w_is_load || w_is_store;
    w_size     = op_size(MEM_Opcode);
    w_misalign = 1'b0;
    case (w_size)
      SZ_HALF: w_misalign = w_access && MEM_ALU_RESULT[0];
      SZ_WORD: w_misalign = w_access && (MEM_ALU_RESULT[1:0] != 2'b00);
      default: w_misalign = 1'b0;
    endcase
    w_start    = (r_state == ST_IDLE) && w_access && !w_misalign;
    w_complete = (r_state == ST_BUSY) && dmem_ready;
  end

  lsu_lane_align u_lane_align (
    .req_size    (w_size),
    .req_lane    (MEM_ALU_RESULT[1:0]),
    .req_data    (MEM_WR_DATA),
    .req_be      (w_be),
    .req_wdata   (w_wdata),
    .ld_size     (r_ld_size),
    .ld_unsigned (r_ld_unsigned),
    .ld_lane     (r_lane),
    .ld_word     (dmem_rdata),
    .ld_data     (w_ld_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_bus_err;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tmo_cnt <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_tmo_cnt <= '0;
      end else if (r_state == ST_BUSY) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
      // High only for the DONE cycle that follows a timeout.
      r_bus_err <= w_timeout;
    end
  end

  // Count value k marks the (k+1)-th BUSY cycle.
  assign w_timeout   = (r_state == ST_BUSY) && !dmem_ready &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign MEM_BUS_ERR = r_bus_err;
`else
  assign w_timeout   = 1'b0;
  assign MEM_BUS_ERR = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and stall. DONE drops the stall for one cycle so MEM/WB
  // captures MEM_RD_DATA before the next instruction can start.
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = w_start;
        if (w_start) w_next_state = ST_BUSY;
      end
      ST_BUSY: begin
        w_stall = 1'b1;
        if (w_complete || w_timeout) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_stall      = 1'b0;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_stall      = 1'b0;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Request latch and load-data register. Request fields stay frozen from
  // launch until completion, so memory may sample them on any BUSY cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_req         <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_be          <= 4'b0000;
      r_wdata       <= '0;
      r_rd_data     <= '0;
      r_is_load     <= 1'b0;
      r_ld_unsigned <= 1'b0;
      r_ld_size     <= SZ_BYTE;
      r_lane        <= 2'b00;
    end else if (w_start) begin
      r_req         <= 1'b1;
      r_we          <= w_is_store;
      r_addr        <= {MEM_ALU_RESULT[ADDR_W-1:2], 2'b00};
      r_be          <= w_be;
      r_wdata       <= w_wdata;
      r_is_load     <= w_is_load;
      r_ld_unsigned <= op_is_unsigned(MEM_Opcode);
      r_ld_size     <= w_size;
      r_lane        <= MEM_ALU_RESULT[1:0];
    end else if (w_complete) begin
      r_req <= 1'b0;
      if (r_is_load) r_rd_data <= w_ld_data;
    end else if (w_timeout) begin
      r_req     <= 1'b0;
      r_rd_data <= '0;
    end
  end

  // Reset forces the combinational flags low as well as the registers.
  assign MEM_STALL    = w_stall && !RESET;
  assign MEM_MISALIGN = w_misalign && (r_state == ST_IDLE) && !RESET;
  assign MEM_RD_DATA  = r_rd_data;
  assign dmem_req     = r_req;
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_be      = r_be;
  assign dmem_wdata   = r_wdata;

endmodule
`default_nettype wire
